// File: rtl/tdm_demux_1to4_pkg.sv
// Package for the 1:4 TDM demultiplexer.
// Holds the channel count, slot index width and type, and the lock FSM states.
// Every other file of the block imports it.
package tdm_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  typedef logic [SEL_W-1:0] slot_t;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } tdm_state_t;

  // One-hot strobe for a given slot; drives dout_valid.
  function automatic logic [NCH-1:0] slot_onehot(input slot_t s);
    logic [NCH-1:0] oh;
    oh = '0;
    oh[s] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/tdm_demux_1to4_if.sv
// Stream and channel bus of the 1:4 TDM demultiplexer.
// Stream side (driven by the link):
//   din, din_valid, frame_sync, resync
// Channel side (driven by the demux):
//   dout, dout_valid, frame_done, sync_err, locked, plus state_dbg/slot_dbg
// Handshake: din_valid alone qualifies a beat. There is no ready; the demux
// accepts every beat on the clock edge where din_valid=1. frame_sync is
// meaningful only on such a beat. Each dout_valid bit, frame_done and
// sync_err are single-cycle pulses with no back-pressure.
// Modports: master = link/testbench side, slave = demux side.
interface tdm_demux_1to4_if #(
  parameter int WIDTH = 8
);
  import tdm_pkg::*;

  logic [WIDTH-1:0]     din;
  logic                 din_valid;
  logic                 frame_sync;
  logic                 resync;
  logic [4*WIDTH-1:0]   dout;
  logic [NCH-1:0]       dout_valid;
  logic                 frame_done;
  logic                 sync_err;
  logic                 locked;
  tdm_state_t           state_dbg;
  slot_t                slot_dbg;

  modport master (
    output din, din_valid, frame_sync, resync,
    input  dout, dout_valid, frame_done, sync_err, locked, state_dbg, slot_dbg
  );

  modport slave (
    input  din, din_valid, frame_sync, resync,
    output dout, dout_valid, frame_done, sync_err, locked, state_dbg, slot_dbg
  );

endinterface

// File: rtl/tdm_demux_1to4_slot_counter.sv
// tdm_slot_counter: 2-bit modulo-4 slot counter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (slot -> 0)
//   clear      : slot <= 0                (highest priority)
//   load1      : slot <= 1                (a channel-0 beat was just taken)
//   inc        : slot <= slot + 1, 3 wraps to 0
//   slot       : current slot
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clear,
  input  logic  load1,
  input  logic  inc,
  output slot_t slot
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (clear) begin
      slot <= '0;
    end else if (load1) begin
      slot <= slot_t'(1);
    end else if (inc) begin
      slot <= slot + slot_t'(1);
    end
  end

endmodule

// File: rtl/tdm_demux_1to4.sv
// tdm_demux_1to4: splits an interleaved ch0..ch3 sample stream into four
// registered channel outputs, aligned by frame_sync.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : tdm_demux_1to4_if.slave (stream in, channels out, debug state)
// All outputs are registered; nothing passes combinationally from in to out.
module tdm_demux_1to4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  tdm_demux_1to4_if.slave   bus
);

  tdm_state_t state, state_n;
  slot_t      slot;
  slot_t      wr_sel;
  logic       wr_en;
  logic       cnt_clr, cnt_load1, cnt_inc;
  logic       fd_n, se_n;

  logic [NCH-1:0][WIDTH-1:0] dout_q;
  logic [NCH-1:0]            dv_q;
  logic                      fd_q, se_q;

  tdm_slot_counter u_slot (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clr),
    .load1 (cnt_load1),
    .inc   (cnt_inc),
    .slot  (slot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_n;
  end

  // resync outranks any beat in the same cycle. A sync beat always lands on
  // ch0 and reloads the slot to 1; a sync beat off slot 0 abandons the
  // partial frame, so it can never raise frame_done.
  always_comb begin
    state_n   = state;
    wr_en     = 1'b0;
    wr_sel    = slot;
    cnt_clr   = 1'b0;
    cnt_load1 = 1'b0;
    cnt_inc   = 1'b0;
    fd_n      = 1'b0;
    se_n      = 1'b0;
    if (bus.resync) begin
      state_n = HUNT;
      cnt_clr = 1'b1;
    end else if (bus.din_valid) begin
      unique case (state)
        HUNT: begin
          if (bus.frame_sync) begin
            wr_en     = 1'b1;
            wr_sel    = '0;
            cnt_load1 = 1'b1;
            state_n   = LOCKED;
          end
        end
        LOCKED: begin
          wr_en = 1'b1;
          if (bus.frame_sync) begin
            wr_sel    = '0;
            cnt_load1 = 1'b1;
            se_n      = (slot != '0);
          end else begin
            cnt_inc = 1'b1;
            fd_n    = (slot == slot_t'(NCH-1));
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
      dv_q   <= '0;
      fd_q   <= 1'b0;
      se_q   <= 1'b0;
    end else begin
      if (wr_en) dout_q[wr_sel] <= bus.din;
      dv_q <= wr_en ? slot_onehot(wr_sel) : '0;
      fd_q <= fd_n;
      se_q <= se_n;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dv_q;
  assign bus.frame_done = fd_q;
  assign bus.sync_err   = se_q;
  assign bus.locked     = (state == LOCKED);
  assign bus.state_dbg  = state;
  assign bus.slot_dbg   = slot;

endmodule
